// File: rtl/s_memory_responder_if.sv
// Client-facing bus of the RC4 S-array responder:
// start/status, both client ports and the shared read data.
interface s_memory_responder_if;
  logic       start;
  logic [7:0] shuf_address;
  logic [7:0] shuf_data;
  logic       shuf_we;
  logic       shuf_finished;
  logic [7:0] dec_address;
  logic [7:0] dec_data;
  logic       dec_we;
  logic       dec_done;
  logic [7:0] s_q;
  logic       client_reset;
  logic       shuf_start;
  logic       dec_start;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output shuf_address, shuf_data,
    output shuf_we, shuf_finished,
    output dec_address, dec_data,
    output dec_we, dec_done,
    input  s_q, client_reset,
    input  shuf_start, dec_start,
    input  busy, done
  );

  modport slave (
    input  start,
    input  shuf_address, shuf_data,
    input  shuf_we, shuf_finished,
    input  dec_address, dec_data,
    input  dec_we, dec_done,
    output s_q, client_reset,
    output shuf_start, dec_start,
    output busy, done
  );
endinterface

// File: rtl/s_memory_responder.sv
// RC4 S-array owner: fills S, then grants the single RAM port
// to the shuffle client and then to the decrypt client.
module s_memory_responder #(
  parameter int DEPTH             = 256,
  parameter int FILL_VALUE_OFFSET = 0
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  s_memory_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FILL,
    SHUF_KICK,
    SHUF_RUN,
    DEC_KICK,
    DEC_RUN,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(DEPTH - 1);
  localparam logic [7:0] OFS  = 8'(FILL_VALUE_OFFSET);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;
  logic       w_we;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE, DONE: begin
        if (bus.start) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = FILL;
      end
      FILL: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = SHUF_KICK;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      SHUF_KICK: w_state_nxt = SHUF_RUN;
      SHUF_RUN: begin
        if (bus.shuf_finished) w_state_nxt = DEC_KICK;
      end
      DEC_KICK: w_state_nxt = DEC_RUN;
      DEC_RUN: begin
        if (bus.dec_done) w_state_nxt = DONE;
      end
    endcase
  end

  // Port grant: the fill engine, then one client per phase.
  always_comb begin
    w_addr  = r_cnt;
    w_wdata = r_cnt + OFS;
    w_we    = 1'b0;
    unique case (r_state)
      FILL: w_we = 1'b1;
      SHUF_KICK, SHUF_RUN: begin
        w_addr  = bus.shuf_address;
        w_wdata = bus.shuf_data;
        w_we    = bus.shuf_we;
      end
      DEC_KICK, DEC_RUN: begin
        w_addr  = bus.dec_address;
        w_wdata = bus.dec_data;
        w_we    = bus.dec_we;
      end
      IDLE, CLEAR, DONE: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_we) r_mem[w_addr] <= w_wdata;
  end

  // Same-edge read of the old word gives read-first behaviour.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_q <= 8'd0;
    else       r_q <= r_mem[w_addr];
  end

  assign bus.s_q          = r_q;
  assign bus.client_reset = (r_state == CLEAR);
  assign bus.shuf_start   = (r_state == SHUF_KICK);
  assign bus.dec_start    = (r_state == DEC_KICK);
  assign bus.busy         = (r_state != IDLE) &&
                            (r_state != DONE);
  assign bus.done         = (r_state == DONE);

endmodule

// File: tb/tb_s_memory_responder.sv
// Bench for s_memory_responder: two instances (offset 0 and 5)
// driven in lockstep, checked against an array model of S.
module tb_s_memory_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s_memory_responder_if ifa ();
  s_memory_responder_if ifb ();

  assign ifb.start         = ifa.start;
  assign ifb.shuf_address  = ifa.shuf_address;
  assign ifb.shuf_data     = ifa.shuf_data;
  assign ifb.shuf_we       = ifa.shuf_we;
  assign ifb.shuf_finished = ifa.shuf_finished;
  assign ifb.dec_address   = ifa.dec_address;
  assign ifb.dec_data      = ifa.dec_data;
  assign ifb.dec_we        = ifa.dec_we;
  assign ifb.dec_done      = ifa.dec_done;

  s_memory_responder #(.FILL_VALUE_OFFSET(0)) dut_a (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (ifa)
  );

  s_memory_responder #(.FILL_VALUE_OFFSET(5)) dut_b (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] ma [256];
  logic [7:0] mb [256];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_model();
    for (int i = 0; i < 256; i++) begin
      ma[i] = 8'(i);
      mb[i] = 8'((i + 5) % 256);
    end
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 256; i++) begin
      ifa.shuf_address = 8'(i);
      tick();
      chk($sformatf("%s_a[%0d]", tag, i), ifa.s_q, ma[i]);
      chk($sformatf("%s_b[%0d]", tag, i), ifb.s_q, mb[i]);
    end
  endtask

  task automatic shuf_write(input logic [7:0] a,
                            input logic [7:0] d,
                            input logic noise);
    logic [7:0] oa;
    logic [7:0] ob;
    oa = ma[a];
    ob = mb[a];
    ifa.shuf_address = a;
    ifa.shuf_data    = d;
    ifa.shuf_we      = 1'b1;
    ifa.dec_we       = noise;
    ifa.dec_address  = 8'($urandom_range(255));
    ifa.dec_data     = ~d;
    tick();
    ifa.shuf_we = 1'b0;
    ifa.dec_we  = 1'b0;
    chk("sw_rdw_a", ifa.s_q, oa);
    chk("sw_rdw_b", ifb.s_q, ob);
    ma[a] = d;
    mb[a] = d;
    tick();
    chk("sw_raw_a", ifa.s_q, d);
    chk("sw_raw_b", ifb.s_q, d);
  endtask

  task automatic dec_write(input logic [7:0] a,
                           input logic [7:0] d,
                           input logic noise);
    logic [7:0] oa;
    oa = ma[a];
    ifa.dec_address  = a;
    ifa.dec_data     = d;
    ifa.dec_we       = 1'b1;
    ifa.shuf_we      = noise;
    ifa.shuf_address = a;
    ifa.shuf_data    = ~d;
    tick();
    ifa.dec_we  = 1'b0;
    ifa.shuf_we = 1'b0;
    chk("dw_rdw_a", ifa.s_q, oa);
    ma[a] = d;
    mb[a] = d;
    tick();
    chk("dw_raw_a", ifa.s_q, d);
    chk("dw_raw_b", ifb.s_q, d);
  endtask

  initial begin
    int n;
    int n_cr;
    int n_ds;
    int n_dn;
    ifa.start         = 1'b0;
    ifa.shuf_address  = 8'd0;
    ifa.shuf_data     = 8'd0;
    ifa.shuf_we       = 1'b0;
    ifa.shuf_finished = 1'b0;
    ifa.dec_address   = 8'd0;
    ifa.dec_data      = 8'd0;
    ifa.dec_we        = 1'b0;
    ifa.dec_done      = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", ifa.busy, 1'b0);
    chk("rst_done", ifa.done, 1'b0);
    chk("rst_sq_a", ifa.s_q, 8'd0);
    chk("rst_sq_b", ifb.s_q, 8'd0);
    chk("rst_pulses",
        {ifa.client_reset, ifa.shuf_start, ifa.dec_start}, 3'b000);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("idle_busy", ifa.busy, 1'b0);

    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("clr_pulse", ifa.client_reset, 1'b1);
    chk("clr_busy", ifa.busy, 1'b1);

    ifa.shuf_finished = 1'b1;
    n = 0; n_cr = 0; n_ds = 0;
    do begin
      tick();
      n++;
      n_cr += int'(ifa.client_reset);
      n_ds += int'(ifa.dec_start);
    end while (!ifa.shuf_start && n < 400);
    ifa.shuf_finished = 1'b0;
    chk("fill_len", n, 257);
    chk("fill_crst", n_cr, 0);
    chk("fill_fin_ignored", n_ds, 0);
    fill_model();
    tick();
    chk("kick_len", ifa.shuf_start, 1'b0);
    chk("shuf_busy", ifa.busy, 1'b1);
    chk("shuf_nodec", ifa.dec_start, 1'b0);
    readback("fill");

    shuf_write(8'h10, 8'hAA, 1'b0);
    ifa.dec_address = 8'h10;
    ifa.dec_data    = 8'h55;
    ifa.dec_we      = 1'b1;
    tick();
    ifa.dec_we       = 1'b0;
    ifa.shuf_address = 8'h10;
    tick();
    chk("dec_we_ignored", ifa.s_q, 8'hAA);
    shuf_write(8'h03, 8'h77, 1'b1);

    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("start_ign_crst", ifa.client_reset, 1'b0);
    chk("start_ign_busy", ifa.busy, 1'b1);

    repeat (24)
      shuf_write(8'($urandom_range(255)),
                 8'($urandom_range(255)),
                 1'($urandom_range(1)));
    readback("shuf");

    ifa.shuf_finished = 1'b1;
    tick();
    ifa.shuf_finished = 1'b0;
    chk("dec_kick", ifa.dec_start, 1'b1);
    ifa.dec_address = 8'd3;
    tick();
    chk("dec_kick_len", ifa.dec_start, 1'b0);
    chk("dec_s3_a", ifa.s_q, ma[3]);
    chk("dec_s3_b", ifb.s_q, mb[3]);
    ifa.shuf_address = 8'd3;
    ifa.shuf_data    = ~ma[3];
    ifa.shuf_we      = 1'b1;
    tick();
    ifa.shuf_we = 1'b0;
    tick();
    chk("shuf_we_ignored", ifa.s_q, ma[3]);
    repeat (8)
      dec_write(8'($urandom_range(255)),
                8'($urandom_range(255)),
                1'($urandom_range(1)));

    ifa.dec_done = 1'b1;
    tick();
    ifa.dec_done = 1'b0;
    chk("done_hi", ifa.done, 1'b1);
    chk("done_busy", ifa.busy, 1'b0);
    tick();
    chk("done_hold", ifa.done, 1'b1);

    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("done_drop", ifa.done, 1'b0);
    chk("re_crst", ifa.client_reset, 1'b1);
    repeat (101) tick();
    for (int i = 0; i < 100; i++) begin
      ma[i] = 8'(i);
      mb[i] = 8'((i + 5) % 256);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", ifa.busy, 1'b0);
    chk("mid_rst_done", ifa.done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    ifa.start = 1'b1;
    tick();
    chk("hold_crst", ifa.client_reset, 1'b1);
    n = 0; n_cr = 0; n_dn = 0;
    do begin
      tick();
      n++;
      n_cr += int'(ifa.client_reset);
      n_dn += int'(ifa.done);
    end while (!ifa.shuf_start && n < 400);
    chk("hold_fill_len", n, 257);
    chk("hold_one_crst", n_cr, 0);
    chk("hold_no_done", n_dn, 0);
    fill_model();
    tick();
    readback("refill");

    ifa.shuf_finished = 1'b1;
    tick();
    ifa.shuf_finished = 1'b0;
    chk("hold_dec_kick", ifa.dec_start, 1'b1);
    tick();
    ifa.dec_done = 1'b1;
    tick();
    ifa.dec_done = 1'b0;
    chk("hold_done", ifa.done, 1'b1);
    tick();
    chk("hold_restart", ifa.client_reset, 1'b1);
    chk("hold_restart_done", ifa.done, 1'b0);
    chk("hold_restart_busy", ifa.busy, 1'b1);

    ifa.start = 1'b0;
    rst = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
